wb_stage: RTL and testbench
===========================

# wb_stage

Writeback pipeline stage of the five-stage MIPS core: captures the MEM-stage result, aligns and extends load data, and drives the register file's single write port (Addr3/WD/RFWr). It also publishes a forwarding tap for the hazard unit and the retirement trace used by the qualifier test harness. It is the only producer of register-file writes. It guarantees r0 is never written, because the register file itself does not protect r0.

## Interface
- LOAD_NONE, 3'd0, non-load: the write value is mem_alu_res
- LOAD_LB/LBU/LH/LHU/LW, 3'd1/2/3/4/5, load-type encodings on mem_load_type; 3'd6 and 3'd7 are treated as LOAD_NONE
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  MEM stage presents an instruction
- in_ready  output  1  stage can accept; equals !wb_hold
- wb_hold  input  1  external freeze (debug/trace backpressure)
- mem_pc  input  32  instruction PC
- mem_alu_res  input  32  ALU result / effective address
- mem_rdata  input  32  raw data-memory word, valid with in_valid
- mem_load_type  input  3  load encoding
- mem_wen  input  1  instruction writes a GPR
- mem_waddr  input  5  destination GPR
- mem_ex  input  1  instruction raised an exception; its write is squashed
- rf_we  output  1  to register file RFWr
- rf_waddr  output  5  to register file Addr3
- rf_wdata  output  32  to register file WD
- fwd_valid  output  1  forwarding tap valid (equals rf_we)
- fwd_addr  output  5  forwarding destination
- fwd_data  output  32  forwarding value (equals rf_wdata)
- debug_wb_pc  output  32  retired PC
- debug_wb_rf_wen  output  4  {4{rf_we}}
- debug_wb_rf_wnum  output  5  equals rf_waddr
- debug_wb_rf_wdata  output  32  equals rf_wdata

## Operation
- State register fields: wb_valid, pc, alu_res, rdata, load_type, wen, waddr.
- Capture: on posedge with in_valid && in_ready, load all fields.
  - Captured wen = mem_wen && !mem_ex && (mem_waddr != 0).
- Without capture:
  - wb_hold=0: wb_valid clears to 0 (bubble).
  - wb_hold=1: all fields retained.
- Write enable: rf_we = wb_valid && wen && !wb_hold. Each instruction writes exactly once, in the cycle its hold releases.
- Load alignment (combinational, little-endian, a = alu_res[1:0]):
  - LB/LBU: byte rdata[8a+7:8a], sign-/zero-extended to 32.
  - LH/LHU: a[1] ? rdata[31:16] : rdata[15:0], sign-/zero-extended to 32.
  - LW: rdata.
  - NONE: alu_res.
- Misaligned half/word loads never reach the write port: MEM sets mem_ex, which squashes wen. For lh/lhu, a[0] is ignored.
- Trace: debug_wb_pc = pc whenever wb_valid. The trace pulses only with rf_we. Squashed or non-writing instructions produce debug_wb_rf_wen = 0.
- When rf_we = 0, rf_waddr, rf_wdata and fwd_addr still reflect the stage contents. Consumers qualify them with rf_we / fwd_valid.

## Timing
- Reset (asynchronous assert; deassert sampled on clk):
  - wb_valid = 0 and all fields = 0.
  - Hence rf_we = 0, fwd_valid = 0, debug_wb_rf_wen = 0, debug_wb_pc = 0, rf_waddr = 0, rf_wdata = 0.
  - in_ready = !wb_hold (combinational).
- Latency:
  - Instruction accepted at edge N.
  - rf_we is high during cycle N..N+1.
  - Register file commits at edge N+1.
  - Forwarding tap is valid in the same cycle as rf_we, covering the read-after-write window before the commit.
- Throughput: one instruction per cycle when wb_hold = 0.
- Hold:
  - in_ready drops in the same cycle as wb_hold.
  - MEM must keep its payload stable while in_ready = 0.
  - Release: the write fires in the first cycle with wb_hold = 0, and the next instruction is captured at the end of that cycle.
- Reset mid-hold: the pending write is discarded. No rf_we pulse follows reset.
- Back-to-back writes to the same register: each is written in order, one per cycle. Forwarding always shows the younger value.

## Test plan
- LB from word 0x80F1_7F02 at a = 0, 1, 2, 3 -> rf_wdata 0x00000002, 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80; LBU at a = 3 -> 0x00000080.
- LH / LHU from 0x8001_7FFF at a = 2 -> 0xFFFF8001 / 0x00008001; at a = 0 -> 0x00007FFF for both.
- ALU op with mem_waddr = 0, mem_wen = 1, res 0xDEADBEEF -> rf_we stays 0 and debug_wb_rf_wen = 0, but debug_wb_pc updates.
- mem_ex = 1 with mem_wen = 1, waddr 5 -> no write; the next instruction (waddr 6, value 0x12) writes normally one cycle later.
- Write to r7 accepted, then wb_hold = 1 for 3 cycles:
  - during hold: rf_we = 0 and in_ready = 0, with fields held;
  - on release: exactly one rf_we pulse with r7's value, and the next input is captured on the same edge.
- Assert rst while a write is held -> all outputs go to 0 immediately, with no write pulse after deassertion. The first post-reset instruction writes at accept edge + 1.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM-stage result, aligns and extends load data,
// and drives the register-file write port, forwarding tap and retirement trace.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        wb_hold,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_alu_res,
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  mem_load_type,
    input  logic        mem_wen,
    input  logic [4:0]  mem_waddr,
    input  logic        mem_ex,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_addr,
    output logic [31:0] fwd_data,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_e;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] alu_res_q,  alu_res_d;
    logic [31:0] rdata_q,    rdata_d;
    logic [2:0]  load_type_q, load_type_d;
    logic        wen_q,      wen_d;
    logic [4:0]  waddr_q,    waddr_d;

    logic        capture;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] wdata;

    assign in_ready = !wb_hold;
    assign capture  = in_valid && in_ready;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        wb_valid_d  = wb_valid_q;
        pc_d        = pc_q;
        alu_res_d   = alu_res_q;
        rdata_d     = rdata_q;
        load_type_d = load_type_q;
        wen_d       = wen_q;
        waddr_d     = waddr_q;
        if (capture) begin
            wb_valid_d  = 1'b1;
            pc_d        = mem_pc;
            alu_res_d   = mem_alu_res;
            rdata_d     = mem_rdata;
            load_type_d = mem_load_type;
            // r0 is filtered here because the register file does not protect it.
            wen_d       = mem_wen && !mem_ex && (mem_waddr != 5'd0);
            waddr_d     = mem_waddr;
        end else if (!wb_hold) begin
            wb_valid_d  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid_q  <= 1'b0;
            pc_q        <= '0;
            alu_res_q   <= '0;
            rdata_q     <= '0;
            load_type_q <= LOAD_NONE;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
        end else begin
            wb_valid_q  <= wb_valid_d;
            pc_q        <= pc_d;
            alu_res_q   <= alu_res_d;
            rdata_q     <= rdata_d;
            load_type_q <= load_type_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
        end
    end

    // Little-endian lane select; halfword loads ignore address bit 0.
    always_comb begin
        byte_sel = rdata_q[7:0];
        case (alu_res_q[1:0])
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase
        half_sel = alu_res_q[1] ? rdata_q[31:16] : rdata_q[15:0];

        wdata = alu_res_q;
        case (load_type_q)
            LOAD_LB:  wdata = {{24{byte_sel[7]}}, byte_sel};
            LOAD_LBU: wdata = {24'd0, byte_sel};
            LOAD_LH:  wdata = {{16{half_sel[15]}}, half_sel};
            LOAD_LHU: wdata = {16'd0, half_sel};
            LOAD_LW:  wdata = rdata_q;
            default:  wdata = alu_res_q;
        endcase
    end

    // Writes fire only once the hold releases, so each instruction commits exactly once.
    assign rf_we             = wb_valid_q && wen_q && !wb_hold;
    assign rf_waddr          = waddr_q;
    assign rf_wdata          = wdata;
    assign fwd_valid         = rf_we;
    assign fwd_addr          = waddr_q;
    assign fwd_data          = wdata;
    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_wen   = {4{rf_we}};
    assign debug_wb_rf_wnum  = waddr_q;
    assign debug_wb_rf_wdata = wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed load/hold/reset scenarios followed by
// randomized traffic, all compared against a behavioural writeback model.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wb_hold = 1'b0;
    logic [31:0] mem_pc = '0;
    logic [31:0] mem_alu_res = '0;
    logic [31:0] mem_rdata = '0;
    logic [2:0]  mem_load_type = '0;
    logic        mem_wen = 1'b0;
    logic [4:0]  mem_waddr = '0;
    logic        mem_ex = 1'b0;
    logic        rf_we, fwd_valid;
    logic [4:0]  rf_waddr, fwd_addr, debug_wb_rf_wnum;
    logic [31:0] rf_wdata, fwd_data, debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;

    int vectors = 0;
    int miscompares = 0;

    // Model of the instruction currently sitting in writeback.
    logic        m_valid = 1'b0;
    logic [31:0] m_pc = '0;
    logic        m_wen = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    // Optional literal value from the test plan, checked on the next comparison point.
    logic        lit_valid = 1'b0;
    logic [31:0] lit_data = '0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .wb_hold(wb_hold),
        .mem_pc(mem_pc), .mem_alu_res(mem_alu_res), .mem_rdata(mem_rdata),
        .mem_load_type(mem_load_type), .mem_wen(mem_wen), .mem_waddr(mem_waddr),
        .mem_ex(mem_ex),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // Load result from arithmetic on the raw word: shift the lane down, mask, extend.
    function automatic logic [31:0] load_value(input logic [2:0] lt, input logic [31:0] addr,
                                              input logic [31:0] word);
        int unsigned a = addr % 4;
        logic [31:0] b = (word >> (8 * a)) & 32'hFF;
        logic [31:0] h = (word >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
        case (lt)
            3'd1:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd4:    return h;
            3'd5:    return word;
            default: return addr;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic we_exp;
        we_exp = m_valid && m_wen && !wb_hold;
        chk("in_ready", in_ready, !wb_hold);
        chk("rf_we", rf_we, we_exp);
        chk("fwd_valid", fwd_valid, we_exp);
        chk("dbg_wen", debug_wb_rf_wen, {4{we_exp}});
        chk("rf_waddr", rf_waddr, m_waddr);
        chk("fwd_addr", fwd_addr, m_waddr);
        chk("dbg_wnum", debug_wb_rf_wnum, m_waddr);
        chk("dbg_pc", debug_wb_pc, m_pc);
        chk("rf_wdata", rf_wdata, m_wdata);
        chk("fwd_data", fwd_data, m_wdata);
        chk("dbg_wdata", debug_wb_rf_wdata, m_wdata);
        if (lit_valid) begin
            chk("plan_value", rf_wdata, lit_data);
            lit_valid = 1'b0;
        end
    endtask

    // One clock: drive at negedge, check the stage as it stands, then advance the model at posedge.
    task automatic drive(input logic v, input logic hold, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] rd, input logic [2:0] lt,
                         input logic wen, input logic [4:0] wa, input logic ex);
        @(negedge clk);
        in_valid = v; wb_hold = hold; mem_pc = pc; mem_alu_res = alu; mem_rdata = rd;
        mem_load_type = lt; mem_wen = wen; mem_waddr = wa; mem_ex = ex;
        #1 check_all();
        @(posedge clk);
        if (v && !hold) begin
            m_valid = 1'b1;
            m_pc    = pc;
            m_wen   = wen && !ex && (wa != 5'd0);
            m_waddr = wa;
            m_wdata = load_value(lt, alu, rd);
        end else if (!hold) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, mem_pc, mem_alu_res, mem_rdata, mem_load_type, mem_wen, mem_waddr, 1'b0);
    endtask

    task automatic expect_value(input logic [31:0] v);
        lit_valid = 1'b1;
        lit_data  = v;
    endtask

    initial begin
        // Reset state
        #12;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        idle();

        // Byte loads from 0x80F17F02
        drive(1, 0, 32'h100, 32'h1000, 32'h80F1_7F02, 3'd1, 1, 5'd3, 0);
        expect_value(32'h0000_0002);
        drive(1, 0, 32'h104, 32'h1001, 32'h80F1_7F02, 3'd1, 1, 5'd3, 0);
        expect_value(32'h0000_007F);
        drive(1, 0, 32'h108, 32'h1002, 32'h80F1_7F02, 3'd1, 1, 5'd3, 0);
        expect_value(32'hFFFF_FFF1);
        drive(1, 0, 32'h10C, 32'h1003, 32'h80F1_7F02, 3'd1, 1, 5'd3, 0);
        expect_value(32'hFFFF_FF80);
        drive(1, 0, 32'h110, 32'h1003, 32'h80F1_7F02, 3'd2, 1, 5'd3, 0);
        expect_value(32'h0000_0080);

        // Halfword loads from 0x80017FFF
        drive(1, 0, 32'h114, 32'h2002, 32'h8001_7FFF, 3'd3, 1, 5'd4, 0);
        expect_value(32'hFFFF_8001);
        drive(1, 0, 32'h118, 32'h2002, 32'h8001_7FFF, 3'd4, 1, 5'd4, 0);
        expect_value(32'h0000_8001);
        drive(1, 0, 32'h11C, 32'h2000, 32'h8001_7FFF, 3'd3, 1, 5'd4, 0);
        expect_value(32'h0000_7FFF);
        drive(1, 0, 32'h120, 32'h2000, 32'h8001_7FFF, 3'd4, 1, 5'd4, 0);
        expect_value(32'h0000_7FFF);

        // Write to r0 is suppressed but still retires into the trace PC
        drive(1, 0, 32'h124, 32'hDEAD_BEEF, 32'h0, 3'd0, 1, 5'd0, 0);
        idle();
        chk("r0_no_write", rf_we, 1'b0);

        // Exception squash, then normal write one cycle later
        drive(1, 0, 32'h128, 32'h55, 32'h0, 3'd0, 1, 5'd5, 1);
        drive(1, 0, 32'h12C, 32'h12, 32'h0, 3'd0, 1, 5'd6, 0);
        expect_value(32'h0000_0012);
        idle();

        // Hold r7 for three cycles, then release with the next instruction waiting
        drive(1, 0, 32'h130, 32'h77, 32'h0, 3'd0, 1, 5'd7, 0);
        for (int i = 0; i < 3; i++)
            drive(1, 1, 32'h134, 32'h88, 32'h0, 3'd0, 1, 5'd8, 0);
        expect_value(32'h0000_0077);
        drive(1, 0, 32'h134, 32'h88, 32'h0, 3'd0, 1, 5'd8, 0);
        expect_value(32'h0000_0088);
        idle();

        // Reset while a write is held
        drive(1, 0, 32'h140, 32'h99, 32'h0, 3'd0, 1, 5'd9, 0);
        drive(0, 1, 32'h0, 32'h0, 32'h0, 3'd0, 0, 5'd0, 0);
        #2 rst = 1'b1;
        #1;
        m_valid = 1'b0; m_pc = '0; m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
        check_all();
        @(negedge clk);
        wb_hold = 1'b0;
        rst = 1'b0;
        idle();
        idle();
        drive(1, 0, 32'h200, 32'hABCD, 32'h0, 3'd0, 1, 5'd10, 0);
        expect_value(32'h0000_ABCD);
        idle();

        // Randomized traffic; misaligned half/word loads raise an exception as MEM would
        for (int i = 0; i < 400; i++) begin
            logic [31:0] addr;
            logic [2:0]  lt;
            logic        ex;
            addr = $urandom;
            lt   = 3'($urandom_range(0, 7));
            ex   = ($urandom_range(0, 9) == 0);
            if ((lt == 3'd3 || lt == 3'd4) && addr[0]) ex = 1'b1;
            if (lt == 3'd5 && addr[1:0] != 2'd0) ex = 1'b1;
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), $urandom, addr,
                  $urandom, lt, ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 31)), ex);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
